// File: rtl/bfs_pkg.sv
// Shared types and constants for the BFS visited-bitmap arbiter and its RAM.
package bfs_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int unsigned RamLatency = 2;

  // Requester-id width; at least one bit so a tag register always exists.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/visited_bitmap_ram.sv
// Single-port 1-bit read-first bitmap with a registered output (2-cycle read latency).
module visited_bitmap_ram #(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 we,
  input  logic                 wdata,
  output logic                 rdata
);

  localparam int unsigned Depth = 1 << ADDR_BITS;

  logic mem [Depth];
  logic rd_q;
  logic out_q;

  // Read-first: rd_q captures the contents before this cycle's write lands.
  always_ff @(posedge clk) begin
    rd_q <= mem[addr];
    if (we) begin
      mem[addr] <= wdata;
    end
    out_q <= rd_q;
  end

  assign rdata = out_q;

endmodule

// File: rtl/visited_arbiter.sv
// Round-robin test-and-set arbiter in front of a shared visited bitmap, with clear sweep.
// Optional response statistics are enabled by defining VISITED_ARB_STATS_EN.
module visited_arbiter
  import bfs_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic [NUM_REQ-1:0]             req_valid_in,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr_in,
  output logic [NUM_REQ-1:0]             req_ready_out,
  output logic [NUM_REQ-1:0]             resp_valid_out,
  output logic                           resp_visited_out,
  input  logic                           clear_start_in,
  output logic                           busy_out,
  output logic                           clear_done_out
`ifdef VISITED_ARB_STATS_EN
  ,
  output logic [31:0]                    new_count_out,
  output logic [31:0]                    hit_count_out
`endif
);

  localparam int unsigned IdW = id_width(NUM_REQ);

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] sweep_q, sweep_d;
  logic [IdW-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt;
  logic                 gnt_any;
  logic [IdW-1:0]       gnt_id;
  logic                 sweep_last;

  logic [RamLatency-1:0] vld_q;
  logic [IdW-1:0]        tag_q [RamLatency];

  logic [ADDR_BITS-1:0] ram_addr;
  logic                 ram_we;
  logic                 ram_wdata;
  logic                 ram_rdata;

  assign sweep_last = (sweep_q == {ADDR_BITS{1'b1}});

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (sweep_last) state_d = RUN;
      RUN:     if (clear_start_in) state_d = CLEAR;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    busy_out       = (state_q == CLEAR);
    clear_done_out = (state_q == CLEAR) && sweep_last;
  end

  // Sweep address counts only in CLEAR, so it is already 0 whenever CLEAR is entered.
  always_comb begin
    sweep_d = (state_q == CLEAR) ? sweep_q + 1'b1 : '0;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sweep_q <= '0;
    end else begin
      sweep_q <= sweep_d;
    end
  end

  // ---------------------------------------------------------- arbiter
  always_comb begin
    logic [IdW-1:0] idx;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    if (state_q == RUN) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = IdW'((32'(ptr_q) + k) % NUM_REQ);
        if (!gnt_any && req_valid_in[idx]) begin
          gnt_any = 1'b1;
          gnt_id  = idx;
        end
      end
    end
    if (gnt_any) begin
      gnt[gnt_id] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = IdW'((32'(gnt_id) + 1) % NUM_REQ);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign req_ready_out = gnt;

  // ------------------------------------------------------- RAM access
  always_comb begin
    if (state_q == CLEAR) begin
      ram_addr  = sweep_q;
      ram_we    = 1'b1;
      ram_wdata = 1'b0;
    end else begin
      ram_addr  = req_addr_in[gnt_id*ADDR_BITS +: ADDR_BITS];
      ram_we    = gnt_any;
      ram_wdata = 1'b1;
    end
  end

  visited_bitmap_ram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk   (clk_in),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Requester tag rides alongside the RAM latency.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < RamLatency; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= gnt_any;
      tag_q[0] <= gnt_id;
      for (int unsigned i = 1; i < RamLatency; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    resp_valid_out   = '0;
    resp_visited_out = 1'b0;
    if (vld_q[RamLatency-1]) begin
      resp_valid_out   = NUM_REQ'(1) << tag_q[RamLatency-1];
      resp_visited_out = ram_rdata;
    end
  end

`ifdef VISITED_ARB_STATS_EN
  // --------------------------------------------------------- statistics
  logic [31:0] new_q, hit_q;
  logic        clear_entry;

  assign clear_entry = (state_q == RUN) && (state_d == CLEAR);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      new_q <= '0;
      hit_q <= '0;
    end else if (clear_entry) begin
      new_q <= '0;
      hit_q <= '0;
    end else if (vld_q[RamLatency-1]) begin
      if (ram_rdata) begin
        if (hit_q != '1) hit_q <= hit_q + 32'd1;
      end else begin
        if (new_q != '1) new_q <= new_q + 32'd1;
      end
    end
  end

  assign new_count_out = new_q;
  assign hit_count_out = hit_q;
`endif

endmodule

// File: doc/visited_arbiter.md
# visited_arbiter

Shares one visited-bitmap RAM between `NUM_REQ` BFS processing elements. It serializes their test-and-set requests with a round-robin arbiter and pipelines them through a read-first BRAM at one access per cycle. Each result (old visited bit) is routed back to the issuing requester. It also owns bitmap initialisation: a full clear sweep after reset and on command. It sits between the per-PE frontier logic and the bitmap storage.

## Interface
- `NUM_REQ`, 4, number of requesters (≥2).
- `ADDR_BITS`, 10, vertex-address width; bitmap depth is 2^ADDR_BITS.
- `clk_in` input 1: single clock.
- `rst_n_in` input 1: reset, asynchronous, active-low.
- `req_valid_in` input NUM_REQ: per-requester request valid.
- `req_addr_in` input NUM_REQ*ADDR_BITS: flattened vertex addresses; requester i uses slice [i*ADDR_BITS +: ADDR_BITS].
- `req_ready_out` output NUM_REQ: one-hot grant; the request is accepted when valid & ready.
- `resp_valid_out` output NUM_REQ: one-hot response strobe.
- `resp_visited_out` output 1: old bit of the granted address; 1 means it was already visited.
- `clear_start_in` input 1: pulse that requests a bitmap clear.
- `busy_out` output 1: high while clearing.
- `clear_done_out` output 1: one-cycle pulse on the last clear write.

## Operation
- FSM states:
  - CLEAR: the write address sweeps 0 to 2^ADDR_BITS−1, writing 0 each cycle. All `req_ready_out` are 0 and `busy_out`=1. On the last address: pulse `clear_done_out`, then go to RUN.
  - RUN: arbitrate and issue. `clear_start_in`=1 moves to CLEAR with the sweep address at 0.
- Reset state is CLEAR: the bitmap is always zeroed after reset, because memory contents are not reset.
- Arbitration is round-robin:
  - Priority pointer resets to 0.
  - The grant goes to the first valid requester at or after the pointer, modulo NUM_REQ.
  - After a grant to i, the pointer becomes (i+1) mod NUM_REQ. With no grant, the pointer holds.
  - At most one grant per cycle. `req_ready_out` is combinational from `req_valid_in`, the pointer and the state.
- Granted access: address = the granted slice, write enable = 1, write data = 1. Read-first returns the prior contents, so one access performs an atomic test-and-set.
- The requester id travels down a 2-stage valid/tag pipeline alongside the RAM latency.
  - The response asserts `resp_valid_out[id]` together with `resp_visited_out`.
- Requesters hold valid and address stable until ready. The block never drops an accepted request.
- `clear_start_in` in the same cycle as a RUN grant: the grant still issues and CLEAR starts next cycle. In-flight responses always drain normally.
- `clear_start_in` while already in CLEAR is ignored; the sweep is not restarted.

## Timing
- Request accepted at cycle t gives the response at t+2. Throughput is one request per cycle.
- Same address back-to-back (t, t+1): the write at t is visible to the access at t+1. The first response is 0 and the second is 1. No hazard logic is needed.
- Clear takes exactly 2^ADDR_BITS cycles. The first grant is possible the cycle after `clear_done_out`.
- Reset values:
  - `req_ready_out`=0, `resp_valid_out`=0, `resp_visited_out`=0.
  - `busy_out`=1, `clear_done_out`=0.
  - pipeline valids 0, pointer 0, sweep address 0.
- Asserting reset mid-operation discards in-flight responses, and nothing is emitted after release. It also aborts the current sweep; the sweep restarts from address 0 on release.

## Configuration
- `VISITED_ARB_STATS_EN` defined: adds outputs `new_count_out` and `hit_count_out` (32 bits each).
  - Each counts responses with visited=0 and visited=1 respectively, saturating at all-ones.
  - Both clear on reset and on entry to CLEAR.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `bfs_pkg`:
  - the FSM state enum (`CLEAR`, `RUN`)
  - the RAM read-latency constant (2)
  - a localparam-style function for the NUM_REQ id width, $clog2(NUM_REQ)
- One sub-module, `visited_bitmap_ram`: single-port, 1-bit wide, read-first, output-registered, 2-cycle latency, depth 2^ADDR_BITS, no init file. The arbiter instantiates it and drives its address, write enable and write data from the FSM/arbiter mux.

## Test plan
- Reset release -> `busy_out` high for 1024 cycles, one `clear_done_out` pulse, then `req_ready_out` asserted for pending valids. Every address probed afterwards reads 0.
- Req0 addr 5 at t -> `resp_valid_out`=0001, visited=0 at t+2. Req0 addr 5 again -> visited=1.
- Req0 and req1 to the same addr 9 on consecutive cycles -> responses in order: req0 visited=0, then req1 visited=1.
- All four requesters valid continuously with distinct addrs, pointer=0 -> grants 0,1,2,3,0… one per cycle. Responses are routed to the matching one-hot bit two cycles later.
- `clear_start_in` while req2 is in flight -> req2 response still delivered. Ready stays low for 1024 cycles. Addr 5 then reads visited=0.
- With `VISITED_ARB_STATS_EN`: 3 new and 2 repeat visits -> `new_count_out`=3 and `hit_count_out`=2. Both are 0 after a clear.
